// File: rtl/cache_line_mem_responder_pkg.sv
// rtl/cache_line_mem_responder_pkg.sv - shared encodings and defaults for the line memory responder
package cache_line_mem_responder_pkg;

    localparam int DEFAULT_ADDR_W     = 6;
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int DEFAULT_LATENCY    = 3;
    localparam int COUNT_W            = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RBURST = 3'd2,
        ST_WBURST = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/cache_line_mem_responder_if.sv
// rtl/cache_line_mem_responder_if.sv - request, write-beat and read-beat handshake bundle
interface cache_line_mem_responder_if
    import cache_line_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;
    logic              wr_done;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_addr, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, wr_done, busy
    );

    modport master (
        output req_valid, req_we, req_addr, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, wr_done, busy
    );

endinterface

// File: rtl/cache_line_mem_responder_mem_array.sv
// rtl/cache_line_mem_responder_mem_array.sv - word array, synchronous write, combinational read
module cache_line_mem_responder_mem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset on the array: contents survive rst_n so a refill after reset sees prior write-backs.
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/cache_line_mem_responder.sv
// rtl/cache_line_mem_responder.sv - backing-memory responder for cache line refill and write-back
module cache_line_mem_responder
    import cache_line_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cache_line_mem_responder_if.slave   io_bus
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int BASE_W = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0]   BEAT_LAST = OFF_W'(LINE_WORDS - 1);
    localparam logic [COUNT_W-1:0] LAT_M1    = COUNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OFF_W-1:0]    r_beat;
    logic [OFF_W-1:0]    w_beat_nxt;
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  w_count_nxt;
    logic [BASE_W-1:0]   r_base;
    logic [BASE_W-1:0]   w_base_nxt;
    logic                r_we;
    logic                w_we_nxt;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused;

    // Line offset bits of the request are don't-care: every burst starts at beat 0.
    assign w_unused = ^io_bus.req_addr[OFF_W-1:0];
    assign w_addr   = {r_base, r_beat};

    cache_line_mem_responder_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (w_addr),
        .wdata (io_bus.wr_data),
        .raddr (w_addr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_count <= '0;
            r_base  <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_count <= w_count_nxt;
            r_base  <= w_base_nxt;
            r_we    <= w_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_nxt       = r_beat;
        w_count_nxt      = r_count;
        w_base_nxt       = r_base;
        w_we_nxt         = r_we;
        w_mem_we         = 1'b0;
        io_bus.req_ready = 1'b0;
        io_bus.wr_ready  = 1'b0;
        io_bus.rd_valid  = 1'b0;
        io_bus.rd_data   = '0;
        io_bus.rd_last   = 1'b0;
        io_bus.wr_done   = 1'b0;
        io_bus.busy      = 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                io_bus.req_ready = 1'b1;
                io_bus.busy      = 1'b0;
                if (io_bus.req_valid) begin
                    w_base_nxt = io_bus.req_addr[ADDR_W-1:OFF_W];
                    w_we_nxt   = io_bus.req_we;
                    w_beat_nxt = '0;
                    if (io_bus.req_we) begin
                        w_state_nxt = ST_WBURST;
                    end else if (LATENCY == 0) begin
                        w_state_nxt = ST_RBURST;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_count_nxt = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_count == '0) begin
                    w_state_nxt = r_we ? ST_ACK : ST_RBURST;
                end else begin
                    w_count_nxt = r_count - COUNT_W'(1);
                end
            end
            ST_RBURST: begin
                io_bus.rd_valid = 1'b1;
                io_bus.rd_data  = w_rdata;
                io_bus.rd_last  = (r_beat == BEAT_LAST);
                if (io_bus.rd_ready) begin
                    w_beat_nxt = r_beat + OFF_W'(1);
                    if (r_beat == BEAT_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WBURST: begin
                io_bus.wr_ready = 1'b1;
                if (io_bus.wr_valid) begin
                    w_mem_we   = 1'b1;
                    w_beat_nxt = r_beat + OFF_W'(1);
                    if (r_beat == BEAT_LAST) begin
                        if (LATENCY == 0) begin
                            w_state_nxt = ST_ACK;
                        end else begin
                            w_state_nxt = ST_WAIT;
                            w_count_nxt = LAT_M1;
                        end
                    end
                end
            end
            ST_ACK: begin
                io_bus.wr_done = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_mem_responder.sv
// tb/tb_cache_line_mem_responder.sv - scoreboard bench for the LATENCY=3 and LATENCY=0 builds
module tb_cache_line_mem_responder;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_line_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();
    cache_line_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

    cache_line_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(4), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .io_bus(bus3)
    );
    cache_line_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(4), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .io_bus(bus0)
    );

    // sel 0 drives the LATENCY=3 build, sel 1 the LATENCY=0 build
    int          sel;
    logic        t_req_valid, t_req_we, t_wr_valid, t_rd_ready;
    logic [5:0]  t_req_addr;
    logic [7:0]  t_wr_data;

    assign bus3.req_valid = (sel == 0) && t_req_valid;
    assign bus3.req_we    = t_req_we;
    assign bus3.req_addr  = t_req_addr;
    assign bus3.wr_valid  = (sel == 0) && t_wr_valid;
    assign bus3.wr_data   = t_wr_data;
    assign bus3.rd_ready  = (sel == 0) && t_rd_ready;
    assign bus0.req_valid = (sel == 1) && t_req_valid;
    assign bus0.req_we    = t_req_we;
    assign bus0.req_addr  = t_req_addr;
    assign bus0.wr_valid  = (sel == 1) && t_wr_valid;
    assign bus0.wr_data   = t_wr_data;
    assign bus0.rd_ready  = (sel == 1) && t_rd_ready;

    logic       m_req_ready, m_wr_ready, m_rd_valid, m_rd_last, m_wr_done, m_busy;
    logic [7:0] m_rd_data;
    assign m_req_ready = (sel == 1) ? bus0.req_ready : bus3.req_ready;
    assign m_wr_ready  = (sel == 1) ? bus0.wr_ready  : bus3.wr_ready;
    assign m_rd_valid  = (sel == 1) ? bus0.rd_valid  : bus3.rd_valid;
    assign m_rd_data   = (sel == 1) ? bus0.rd_data   : bus3.rd_data;
    assign m_rd_last   = (sel == 1) ? bus0.rd_last   : bus3.rd_last;
    assign m_wr_done   = (sel == 1) ? bus0.wr_done   : bus3.wr_done;
    assign m_busy      = (sel == 1) ? bus0.busy      : bus3.busy;

    int         n_checks;
    int         n_fail;
    logic [7:0] model [0:1][0:63];
    logic [7:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input logic [5:0] addr, input logic [31:0] line, input int gap_after);
        int lat;
        lat = (sel == 1) ? 0 : 3;
        n_checks++;
        if (m_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_req_ready: got %b want 1", m_req_ready);
        end
        t_req_valid = 1'b1; t_req_we = 1'b1; t_req_addr = addr;
        tick();
        t_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (m_wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL wr_ready beat %0d: got %b want 1", i, m_wr_ready);
            end
            t_wr_valid = 1'b1; t_wr_data = line[8*i +: 8];
            tick();
            model[sel][{addr[5:2], 2'(i)}] = line[8*i +: 8];
            t_wr_valid = 1'b0;
            if (i == gap_after) tick();
        end
        for (int k = 0; k <= lat; k++) begin
            n_checks++;
            if (m_wr_done !== 1'(k == lat)) begin
                n_fail++; $display("FAIL wr_done_timing +%0d: got %b want %b", k, m_wr_done, k == lat);
            end
            if (k < lat) tick();
        end
        tick();
        n_checks++;
        if (m_wr_done !== 1'b0 || m_busy !== 1'b0 || m_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_done_pulse: done=%b busy=%b req_ready=%b want 0 0 1",
                               m_wr_done, m_busy, m_req_ready);
        end
    endtask

    task automatic read_line(input logic [5:0] addr, input int stall_beat, input int stall_cycles,
                             input bit poke);
        int         lat;
        logic [7:0] exp_d;
        lat = (sel == 1) ? 0 : 3;
        n_checks++;
        if (m_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_req_ready: got %b want 1", m_req_ready);
        end
        t_rd_ready = 1'b1; t_req_valid = 1'b1; t_req_we = 1'b0; t_req_addr = addr;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[sel][{addr[5:2], 2'(i)}]);
        tick();
        t_req_valid = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            n_checks++;
            if (m_rd_valid !== 1'(k == lat)) begin
                n_fail++; $display("FAIL rd_valid_timing +%0d: got %b want %b", k, m_rd_valid, k == lat);
            end
            if (poke && k < lat) begin
                n_checks++;
                if (m_req_ready !== 1'b0) begin
                    n_fail++; $display("FAIL req_ready_in_wait: got %b want 0", m_req_ready);
                end
                t_req_valid = 1'b1; t_req_we = 1'b1; t_req_addr = 6'h20;
            end
            if (k < lat) tick();
        end
        for (int b = 0; b < 4; b++) begin
            if (poke) begin
                t_req_valid = 1'b1; t_req_we = 1'b1; t_req_addr = 6'h20;
                t_wr_valid = 1'b1; t_wr_data = 8'hEE;
                n_checks++;
                if (m_req_ready !== 1'b0 || m_wr_ready !== 1'b0) begin
                    n_fail++; $display("FAIL ready_in_rburst: req_ready=%b wr_ready=%b want 0 0",
                                       m_req_ready, m_wr_ready);
                end
            end
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard_empty beat %0d: got empty queue want entry", b);
                exp_d = 8'h00;
            end else begin
                exp_d = exp_q.pop_front();
            end
            if (b == stall_beat) begin
                t_rd_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    tick();
                    n_checks++;
                    if (m_rd_valid !== 1'b1 || m_rd_data !== exp_d || m_rd_last !== 1'(b == 3)) begin
                        n_fail++; $display("FAIL stall_hold beat %0d: valid=%b data=%h last=%b want 1 %h %b",
                                           b, m_rd_valid, m_rd_data, m_rd_last, exp_d, b == 3);
                    end
                end
                t_rd_ready = 1'b1;
            end
            n_checks++;
            if (m_rd_valid !== 1'b1 || m_rd_data !== exp_d || m_rd_last !== 1'(b == 3)) begin
                n_fail++; $display("FAIL rd_beat %0d: valid=%b data=%h last=%b want 1 %h %b",
                                   b, m_rd_valid, m_rd_data, m_rd_last, exp_d, b == 3);
            end
            tick();
        end
        t_req_valid = 1'b0; t_wr_valid = 1'b0;
        n_checks++;
        if (m_rd_valid !== 1'b0 || m_req_ready !== 1'b1 || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL rd_end: valid=%b req_ready=%b busy=%b want 0 1 0",
                               m_rd_valid, m_req_ready, m_busy);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            n_checks++;
            if (m_req_ready !== 1'b1 || m_wr_ready !== 1'b0 || m_rd_valid !== 1'b0 || m_rd_last !== 1'b0 ||
                m_rd_data !== 8'h00 || m_wr_done !== 1'b0 || m_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs sel %0d: rr=%b wr=%b rv=%b rl=%b rd=%h wd=%b busy=%b want 1 0 0 0 00 0 0",
                         s, m_req_ready, m_wr_ready, m_rd_valid, m_rd_last, m_rd_data, m_wr_done, m_busy);
            end
        end
        sel = 0;
    endtask

    task automatic test_write_line();
        sel = 0;
        write_line(6'h08, {8'h44, 8'h33, 8'h22, 8'h11}, 1);
    endtask

    task automatic test_read_line();
        sel = 0;
        read_line(6'h0B, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 0;
        read_line(6'h08, 1, 5, 1'b0);
    endtask

    task automatic test_overlap();
        sel = 0;
        read_line(6'h09, -1, 0, 1'b1);
        tick();
        n_checks++;
        if (m_busy !== 1'b0 || m_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL overlap_not_queued: busy=%b rd_valid=%b want 0 0", m_busy, m_rd_valid);
        end
        read_line(6'h08, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        sel = 0;
        t_rd_ready = 1'b1; t_req_valid = 1'b1; t_req_we = 1'b0; t_req_addr = 6'h08;
        tick();
        t_req_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b0 || m_req_ready !== 1'b1 || m_rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_read: rd_valid=%b req_ready=%b rd_data=%h want 0 1 00",
                               m_rd_valid, m_req_ready, m_rd_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        write_line(6'h3C, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, -1);
        t_req_valid = 1'b1; t_req_we = 1'b1; t_req_addr = 6'h3E;
        tick();
        t_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_wr_valid = 1'b1; t_wr_data = 8'hB1 + 8'(i);
            tick();
            model[0][6'h3C + 6'(i)] = 8'hB1 + 8'(i);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_wr_ready !== 1'b0 || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_write: wr_ready=%b busy=%b want 0 0", m_wr_ready, m_busy);
        end
        t_wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        read_line(6'h3C, -1, 0, 1'b0);
    endtask

    task automatic test_latency0();
        sel = 1;
        tick();
        write_line(6'h00, {8'h04, 8'h03, 8'h02, 8'h01}, -1);
        write_line(6'h3C, {8'hF4, 8'hF3, 8'hF2, 8'hF1}, 1);
        read_line(6'h3D, -1, 0, 1'b0);
        read_line(6'h00, 2, 2, 1'b0);
        sel = 0;
    endtask

    task automatic test_back_to_back();
        sel = 0;
        read_line(6'h0B, -1, 0, 1'b0);
        read_line(6'h3C, -1, 0, 1'b0);
        write_line(6'h10, {8'h5A, 8'hC3, 8'h00, 8'hFF}, -1);
        read_line(6'h13, 3, 2, 1'b0);
    endtask

    initial begin
        sel = 0; n_checks = 0; n_fail = 0;
        t_req_valid = 1'b0; t_req_we = 1'b0; t_req_addr = '0;
        t_wr_valid = 1'b0; t_wr_data = '0; t_rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_write_line();
        test_read_line();
        test_backpressure();
        test_overlap();
        test_reset_mid_burst();
        test_latency0();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
